// File: rtl/vector_alu_pipe.sv
// Elastic, DEPTH-stage pipelined vector ALU: LANES x LANE_W lanes, 3-bit opcodes,
// per-lane write masks, scalar/vector mode, valid/ready handshake with bubble collapsing.
module vector_alu_pipe #(
  parameter int LANES  = 6,
  parameter int LANE_W = 32,
  parameter int DEPTH  = 3,
  parameter int TAG_W  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [2:0]                in_op,
  input  logic                      in_vector,
  input  logic [LANES-1:0]          in_mask,
  input  logic [LANES*LANE_W-1:0]   in_a,
  input  logic [LANES*LANE_W-1:0]   in_b,
  input  logic [TAG_W-1:0]          in_tag,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*LANE_W-1:0]   out_result,
  output logic                      out_zero,
  output logic [TAG_W-1:0]          out_tag,
  output logic                      busy
);

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_MUL  = 3'b010,
    OP_SADD = 3'b011,
    OP_AND  = 3'b100,
    OP_OR   = 3'b101,
    OP_MAX  = 3'b110,
    OP_PASS = 3'b111
  } alu_op_e;

  localparam int DW = LANES * LANE_W;

  alu_op_e            op;
  logic [LANE_W-1:0]  a_l, b_l, r_l;
  logic [LANE_W:0]    sum_l;
  logic [DW-1:0]      lane_res;
  logic               lane_zero;

  logic [DEPTH-1:0]   v_q, v_d;
  logic [DEPTH-1:0]   zero_q, zero_d;
  logic [DW-1:0]      res_q [DEPTH];
  logic [DW-1:0]      res_d [DEPTH];
  logic [TAG_W-1:0]   tag_q [DEPTH];
  logic [TAG_W-1:0]   tag_d [DEPTH];
  logic [DEPTH-1:0]   rdy;
  logic               tail_open;

  always_comb begin
    op       = alu_op_e'(in_op);
    lane_res = '0;
    a_l      = '0;
    b_l      = '0;
    r_l      = '0;
    sum_l    = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      a_l   = in_a[i*LANE_W +: LANE_W];
      b_l   = in_b[i*LANE_W +: LANE_W];
      sum_l = {1'b0, a_l} + {1'b0, b_l};
      if (!in_vector && i != 0) begin
        r_l = '0;
      end else if (!in_mask[i]) begin
        r_l = a_l;
      end else begin
        case (op)
          OP_ADD:  r_l = sum_l[LANE_W-1:0];
          OP_SUB:  r_l = a_l - b_l;
          OP_MUL:  r_l = a_l * b_l;
          OP_SADD: r_l = sum_l[LANE_W] ? '1 : sum_l[LANE_W-1:0];
          OP_AND:  r_l = a_l & b_l;
          OP_OR:   r_l = a_l | b_l;
          OP_MAX:  r_l = (a_l > b_l) ? a_l : b_l;
          default: r_l = b_l;
        endcase
      end
      lane_res[i*LANE_W +: LANE_W] = r_l;
    end
    lane_zero = ~|lane_res;
  end

  // rdy_k = ~v_k | rdy_{k+1} unrolled: stage k can move if any stage at or
  // downstream of it is empty, or the consumer is taking the output.
  always_comb begin
    rdy       = '0;
    tail_open = 1'b0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      tail_open = 1'b0;
      for (int unsigned j = k; j < DEPTH; j++) begin
        tail_open = tail_open | ~v_q[j];
      end
      rdy[k] = out_ready | tail_open;
    end
  end

  always_comb begin
    v_d    = v_q;
    zero_d = zero_q;
    res_d  = res_q;
    tag_d  = tag_q;
    if (rdy[0]) begin
      v_d[0] = in_valid;
      if (in_valid) begin
        res_d[0]  = lane_res;
        zero_d[0] = lane_zero;
        tag_d[0]  = in_tag;
      end
    end
    for (int unsigned k = 1; k < DEPTH; k++) begin
      if (rdy[k]) begin
        v_d[k] = v_q[k-1];
        if (v_q[k-1]) begin
          res_d[k]  = res_q[k-1];
          zero_d[k] = zero_q[k-1];
          tag_d[k]  = tag_q[k-1];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q    <= '0;
      zero_q <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        res_q[k] <= '0;
        tag_q[k] <= '0;
      end
    end else begin
      v_q    <= v_d;
      zero_q <= zero_d;
      res_q  <= res_d;
      tag_q  <= tag_d;
    end
  end

  assign in_ready   = rdy[0] & ~rst;
  assign busy       = |v_q;
  assign out_valid  = v_q[DEPTH-1];
  assign out_result = res_q[DEPTH-1];
  assign out_zero   = zero_q[DEPTH-1];
  assign out_tag    = tag_q[DEPTH-1];

endmodule
